// File: rtl/wb_regfile.sv
// Write-back stage register plus 32-entry GPR file with two bypassed read ports.
// Pending write commits one edge after capture; commits are counted for debug.

module wb_rf_rd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              byp_we,
  input  logic [ADDR_W-1:0] byp_addr,
  input  logic [DATA_W-1:0] byp_data,
  input  logic              pend_we,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [DATA_W-1:0] pend_data,
  input  logic [DATA_W-1:0] gpr_data,
  output logic [DATA_W-1:0] rdata
);
  // Newest in-flight value wins: incoming stage result, then WB register, then array.
  always_comb begin
    rdata = gpr_data;
    if (rst || !en || raddr == '0)              rdata = '0;
    else if (byp_we && byp_addr == raddr)       rdata = byp_data;
    else if (pend_we && pend_addr == raddr)     rdata = pend_data;
  end
endmodule

module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              pend_we_o,
  output logic [ADDR_W-1:0] pend_addr_o,
  output logic [31:0]       commit_cnt_o
);
  localparam int NRD = 2;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  wb_req_t                        pend, wb_in;
  logic [NREGS-1:0][DATA_W-1:0]   gpr;
  logic [31:0]                    cnt;
  logic                           adv, commit, byp_we;
  logic [NRD-1:0]                 re;
  logic [NRD-1:0][ADDR_W-1:0]     raddr;
  logic [NRD-1:0][DATA_W-1:0]     rdata;

  assign wb_in  = '{we: wb_we_i, addr: wb_addr_i, data: wb_data_i};
  // Flush overrides stall: the pending write still retires while a bubble loads.
  assign adv    = !stall_i || flush_i;
  assign commit = adv && pend.we && (pend.addr != '0);
  assign byp_we = wb_we_i && !flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpr  <= '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (adv) pend <= flush_i ? '0 : wb_in;
      if (commit) begin
        gpr[pend.addr] <= pend.data;
        cnt            <= cnt + 32'd1;
      end
    end
  end

  assign re    = {re2_i, re1_i};
  assign raddr = {raddr2_i, raddr1_i};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    wb_rf_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .rst      (rst),
      .en       (re[p]),
      .raddr    (raddr[p]),
      .byp_we   (byp_we),
      .byp_addr (wb_addr_i),
      .byp_data (wb_data_i),
      .pend_we  (pend.we),
      .pend_addr(pend.addr),
      .pend_data(pend.data),
      .gpr_data (gpr[raddr[p]]),
      .rdata    (rdata[p])
    );
  end

  assign rdata1_o     = rdata[0];
  assign rdata2_o     = rdata[1];
  assign pend_we_o    = pend.we;
  assign pend_addr_o  = pend.addr;
  assign commit_cnt_o = cnt;
endmodule
